uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter (8-bit write_data/write_en in, tx_busy out) between NUM_SRC packet sources.
- Each source raises a request with a byte count. The block grants sources round-robin and fetches bytes one at a time through a per-source read port.
- Each byte goes to the transmitter as a one-cycle write pulse, paced by the tx_busy rise/fall handshake. The block replaces free-running, timer-triggered string senders.

---
 rtl/uart_tx_arbiter_if.sv | 45 ++++
 rtl/uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: source read ports, grant/done and UART write side
// of the shared transmitter arbiter, bundled for one port connection.
interface uart_tx_arbiter_if #(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC-1:0]   src_req;
    logic [8*NUM_SRC-1:0] src_len;
    logic [NUM_SRC-1:0]   src_rd_en;
    logic [7:0]           src_rd_addr;
    logic [8*NUM_SRC-1:0] src_rd_data;
    logic [NUM_SRC-1:0]   src_grant;
    logic [NUM_SRC-1:0]   src_done;
    logic                 tx_busy;
    logic [7:0]           write_data;
    logic                 write_en;
    logic                 err_timeout;

    modport master (
        input  src_req,
        input  src_len,
        input  src_rd_data,
        input  tx_busy,
        output src_rd_en,
        output src_rd_addr,
        output src_grant,
        output src_done,
        output write_data,
        output write_en,
        output err_timeout
    );

    modport slave (
        output src_req,
        output src_len,
        output src_rd_data,
        output tx_busy,
        input  src_rd_en,
        input  src_rd_addr,
        input  src_grant,
        input  src_done,
        input  write_data,
        input  write_en,
        input  err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_SRC packet sources. Define UART_TX_ARB_CRLF_EN to append CR LF.
module uart_tx_arbiter #(
    parameter int NUM_SRC = 2,
    parameter int BUSY_TO = 1024
) (
    input logic               clk,
    input logic               rst,
    uart_tx_arbiter_if.master bus
);
    localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TW = (BUSY_TO > 1) ? $clog2(BUSY_TO) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        FETCH,
        LOAD,
        WAIT_HI,
        WAIT_LO,
`ifdef UART_TX_ARB_CRLF_EN
        TERM,
`endif
        DONE
    } state_t;

    state_t state, state_n;

    logic [NUM_SRC-1:0] grant, grant_n;
    logic [NUM_SRC-1:0] done, done_n;
    logic [PW-1:0]      win, win_n;
    logic [PW-1:0]      rr, rr_n;
    logic [7:0]         len, len_n;
    logic [7:0]         cnt, cnt_n;
    logic [TW-1:0]      timer, timer_n;
    logic [7:0]         wdata, wdata_n;
    logic               wen, wen_n;
    logic               err, err_n;
    logic               busy_q;
`ifdef UART_TX_ARB_CRLF_EN
    logic [1:0]         term, term_n;
`endif

    logic               found;
    logic [PW-1:0]      pick;
    int                 idx;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = int'(rr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (!found && bus.src_req[PW'(idx)]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Next-state and next-register values for the packet sequencer.
    always_comb begin
        state_n = state;
        grant_n = grant;
        win_n   = win;
        rr_n    = rr;
        len_n   = len;
        cnt_n   = cnt;
        timer_n = timer;
        wdata_n = wdata;
        wen_n   = 1'b0;
        done_n  = '0;
        err_n   = err;
`ifdef UART_TX_ARB_CRLF_EN
        term_n  = term;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    win_n         = pick;
                    len_n         = bus.src_len[8*pick +: 8];
                    cnt_n         = 8'h00;
                    rr_n          = (pick == PW'(NUM_SRC - 1)) ? '0
                                                               : pick + 1'b1;
`ifdef UART_TX_ARB_CRLF_EN
                    term_n        = 2'd0;
`endif
                    state_n       = CHECK;
                end
            end
            CHECK: begin
                if (len == 8'h00) begin
`ifdef UART_TX_ARB_CRLF_EN
                    state_n = TERM;
`else
                    state_n = DONE;
`endif
                end else begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                wdata_n = bus.src_rd_data[8*win +: 8];
                wen_n   = 1'b1;
                timer_n = '0;
                state_n = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_n = WAIT_LO;
                end else if (timer == TW'(BUSY_TO - 1)) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            WAIT_LO: begin
                if (busy_q && !bus.tx_busy) begin
`ifdef UART_TX_ARB_CRLF_EN
                    if (term == 2'd2) begin
                        state_n = DONE;
                    end else if (term == 2'd1) begin
                        state_n = TERM;
                    end else begin
                        cnt_n   = cnt + 8'd1;
                        state_n = (cnt + 8'd1 == len) ? TERM : FETCH;
                    end
`else
                    cnt_n   = cnt + 8'd1;
                    state_n = (cnt + 8'd1 == len) ? DONE : FETCH;
`endif
                end
            end
`ifdef UART_TX_ARB_CRLF_EN
            TERM: begin
                wdata_n = (term == 2'd0) ? 8'h0D : 8'h0A;
                term_n  = term + 2'd1;
                wen_n   = 1'b1;
                timer_n = '0;
                state_n = WAIT_HI;
            end
`endif
            DONE: begin
                done_n  = grant;
                grant_n = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Grant, counters and registered transmitter-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant  <= '0;
            done   <= '0;
            win    <= '0;
            rr     <= '0;
            len    <= 8'h00;
            cnt    <= 8'h00;
            timer  <= '0;
            wdata  <= 8'h00;
            wen    <= 1'b0;
            err    <= 1'b0;
            busy_q <= 1'b0;
`ifdef UART_TX_ARB_CRLF_EN
            term   <= 2'd0;
`endif
        end else begin
            grant  <= grant_n;
            done   <= done_n;
            win    <= win_n;
            rr     <= rr_n;
            len    <= len_n;
            cnt    <= cnt_n;
            timer  <= timer_n;
            wdata  <= wdata_n;
            wen    <= wen_n;
            err    <= err_n;
            busy_q <= bus.tx_busy;
`ifdef UART_TX_ARB_CRLF_EN
            term   <= term_n;
`endif
        end
    end

    assign bus.src_grant   = grant;
    assign bus.src_done    = done;
    assign bus.src_rd_en   = (state == FETCH) ? grant : '0;
    assign bus.src_rd_addr = (state == FETCH) ? cnt : 8'h00;
    assign bus.write_data  = wdata;
    assign bus.write_en    = wen;
    assign bus.err_timeout = err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a 10-cycle UART busy model
// and per-source byte memories; BUSY_TO is 16 for the timeout case.
module tb_uart_tx_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_SRC(N)) bus ();

    uart_tx_arbiter #(
        .NUM_SRC(N),
        .BUSY_TO(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [7:0]   mem [N][8];
    logic [8*N-1:0] rdd;
    logic [N-1:0] drop_en;
    logic         uart_on;
    int           ubusy;
    int           n_tests;
    int           n_fail;
    int           wr_q[$];
    int           addr_q[$];
    int           done_q[$];
    int           exp_q[$];
    int           rd_cnt;
    int           overlap;

    // Source byte memories: data valid the cycle after the fetch strobe.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bus.src_rd_en[i]) begin
                rdd[8*i +: 8] <= mem[i][bus.src_rd_addr[2:0]];
            end
        end
    end
    assign bus.src_rd_data = rdd;

    // UART model: busy for 10 cycles after each accepted write.
    always @(posedge clk) begin
        if (rst) begin
            ubusy <= 0;
        end else if (uart_on && bus.write_en) begin
            ubusy <= 10;
        end else if (ubusy > 0) begin
            ubusy <= ubusy - 1;
        end
    end
    assign bus.tx_busy = (ubusy > 0);

    // Passive log of writes, fetches and grant overlap.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus.write_en) wr_q.push_back(int'(bus.write_data));
            if (|bus.src_rd_en) begin
                rd_cnt <= rd_cnt + 1;
                addr_q.push_back(int'(bus.src_rd_addr));
            end
            if ($countones(bus.src_grant) > 1) overlap <= overlap + 1;
        end
    end

    initial begin
        rd_cnt  = 0;
        overlap = 0;
    end

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (bus.src_done[i] === 1'b1) begin
                done_q.push_back(i);
                if (drop_en[i]) bus.src_req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_done(string tag, int n, int budget);
        int k;
        k = 0;
        while (done_q.size() < n && k < budget) begin
            step();
            k++;
        end
        check(tag, done_q.size(), n);
    endtask

    task automatic crlf();
`ifdef UART_TX_ARB_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic check_writes(string tag, int base);
        int got_n;
        got_n = wr_q.size() - base;
        check({tag, "_nwr"}, got_n, exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_n; k++) begin
            check($sformatf("%s_wr%0d", tag, k), wr_q[base + k], exp_q[k]);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.src_req = '0;
        bus.src_len = '0;
        drop_en     = '1;
        uart_on     = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, ab, rb, d0, k;
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 8; j++)
                mem[i][j] = 8'h00;

        // Reset state
        do_reset();
        check("rst_grant", int'(bus.src_grant), 0);
        check("rst_done", int'(bus.src_done), 0);
        check("rst_wen", int'(bus.write_en), 0);
        check("rst_wdata", int'(bus.write_data), 0);
        check("rst_rden", int'(bus.src_rd_en), 0);
        check("rst_err", int'(bus.err_timeout), 0);

        // Single source, three bytes
        mem[0][0] = 8'h41;
        mem[0][1] = 8'h42;
        mem[0][2] = 8'h43;
        bus.src_len[7:0] = 8'd3;
        wb = wr_q.size();
        ab = addr_q.size();
        d0 = done_q.size();
        bus.src_req = 2'b01;
        step();
        check("t1_grant", int'(bus.src_grant), 1);
        wait_done("t1_done", d0 + 1, 400);
        repeat (3) step();
        check("t1_ndone", done_q.size(), d0 + 1);
        if (done_q.size() > d0) check("t1_who", done_q[d0], 0);
        exp_q.delete();
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        crlf();
        check_writes("t1", wb);
        check("t1_naddr", addr_q.size() - ab, 3);
        for (int a = 0; a < 3 && ab + a < addr_q.size(); a++) begin
            check($sformatf("t1_addr%0d", a), addr_q[ab + a], a);
        end

        // Both sources from reset, two bytes each
        do_reset();
        mem[0][0] = 8'hA0;
        mem[0][1] = 8'hA1;
        mem[1][0] = 8'hB0;
        mem[1][1] = 8'hB1;
        bus.src_len = {8'd2, 8'd2};
        wb = wr_q.size();
        d0 = done_q.size();
        k  = overlap;
        bus.src_req = 2'b11;
        step();
        check("t2_grant", int'(bus.src_grant), 1);
        wait_done("t2_done", d0 + 2, 800);
        if (done_q.size() > d0 + 1) begin
            check("t2_first", done_q[d0], 0);
            check("t2_second", done_q[d0 + 1], 1);
        end
        exp_q.delete();
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        crlf();
        exp_q.push_back(8'hB0);
        exp_q.push_back(8'hB1);
        crlf();
        check_writes("t2", wb);
        check("t2_overlap", overlap - k, 0);

        // Source 0 keeps requesting through its done; source 1 wins next
        do_reset();
        mem[0][0] = 8'hC0;
        mem[1][0] = 8'hD0;
        bus.src_len = {8'd1, 8'd1};
        drop_en = 2'b10;
        d0 = done_q.size();
        bus.src_req = 2'b01;
        repeat (3) step();
        bus.src_req[1] = 1'b1;
        wait_done("t3_done", d0 + 2, 800);
        if (done_q.size() > d0 + 1) begin
            check("t3_first", done_q[d0], 0);
            check("t3_second", done_q[d0 + 1], 1);
        end
        drop_en = 2'b11;
        wait_done("t3_again", d0 + 3, 400);
        if (done_q.size() > d0 + 2) check("t3_third", done_q[d0 + 2], 0);

        // Zero-length packet on source 1
        do_reset();
        bus.src_len = {8'd0, 8'd0};
        wb = wr_q.size();
        rb = rd_cnt;
        d0 = done_q.size();
        bus.src_req = 2'b10;
        k = 0;
        while (done_q.size() == d0 && k < 200) begin
            step();
            k++;
        end
`ifndef UART_TX_ARB_CRLF_EN
        check("t4_latency", k, 3);
`endif
        check("t4_ndone", done_q.size(), d0 + 1);
        if (done_q.size() > d0) check("t4_who", done_q[d0], 1);
        repeat (2) step();
        check("t4_rden", rd_cnt - rb, 0);
        exp_q.delete();
        crlf();
        check_writes("t4", wb);

        // Lost byte: transmitter never goes busy
        do_reset();
        uart_on = 1'b0;
        mem[0][0] = 8'h11;
        mem[0][1] = 8'h22;
        bus.src_len[7:0] = 8'd2;
        wb = wr_q.size();
        d0 = done_q.size();
        bus.src_req = 2'b01;
        k = 0;
        while (bus.write_en !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        check("t5_wen_seen", int'(bus.write_en), 1);
        k = 0;
        while (bus.err_timeout !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check("t5_to_cycles", k, 16);
        check("t5_err", int'(bus.err_timeout), 1);
        wait_done("t5_done", d0 + 1, 50);
        exp_q.delete();
        exp_q.push_back(8'h11);
        check_writes("t5", wb);
        uart_on = 1'b1;
        mem[1][0] = 8'h77;
        bus.src_len[15:8] = 8'd1;
        wb = wr_q.size();
        bus.src_req = 2'b10;
        wait_done("t5_next", d0 + 2, 400);
        exp_q.delete();
        exp_q.push_back(8'h77);
        crlf();
        check_writes("t5n", wb);
        check("t5_sticky", int'(bus.err_timeout), 1);

        // One byte, with terminator when enabled
        do_reset();
        mem[0][0] = 8'h55;
        bus.src_len[7:0] = 8'd1;
        wb = wr_q.size();
        d0 = done_q.size();
        bus.src_req = 2'b01;
        wait_done("t6_done", d0 + 1, 400);
        exp_q.delete();
        exp_q.push_back(8'h55);
        crlf();
        check_writes("t6", wb);

        // Reset in the middle of a packet: no done
        do_reset();
        mem[0][0] = 8'h01;
        mem[0][1] = 8'h02;
        mem[0][2] = 8'h03;
        bus.src_len[7:0] = 8'd3;
        d0 = done_q.size();
        bus.src_req = 2'b01;
        repeat (6) step();
        rst = 1'b1;
        bus.src_req = 2'b00;
        repeat (2) step();
        rst = 1'b0;
        repeat (4) step();
        check("t7_nodone", done_q.size(), d0);
        check("t7_grant", int'(bus.src_grant), 0);
        check("t7_wen", int'(bus.write_en), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
